// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_pkg;

    localparam int DIV_DEFAULT       = 20;
    localparam int GAP_TICKS_DEFAULT = 4;
    localparam int NUM_CMDS_DEFAULT  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        XFER   = 3'd2,
        GAP    = 3'd3,
        RECV   = 3'd4
    } state_t;

    // Bytes per command, indexed by data_select: [0]=3, [1]=3, [2]=2, [3]=3.
    localparam logic [3:0][2:0] CMD_SIZE = {3'd3, 3'd2, 3'd3, 3'd3};

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: half-period counter toggling sclk, with a one-cycle pulse on each rising edge.
module spi_sclk_gen #(
    parameter int DIV = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic sclk,
    output logic sclk_rise
);

    localparam int HALF = DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] div_cnt;

    // Count half periods; toggle sclk at wrap and flag the 0->1 toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            sclk      <= 1'b0;
            sclk_rise <= 1'b0;
        end else begin
            sclk_rise <= 1'b0;
            if (div_cnt == CW'(HALF - 1)) begin
                div_cnt   <= '0;
                sclk      <= ~sclk;
                sclk_rise <= ~sclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI master control: steps through the fixed write commands, then parks in receive.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int GAP_TICKS = GAP_TICKS_DEFAULT,
    parameter int NUM_CMDS  = NUM_CMDS_DEFAULT
) (
    input  logic       clk,
    input  logic       power_btn,
    output logic       sclk,
    output logic       sclk_rise,
    output logic       cs,
    output logic [1:0] data_select,
    output logic       transfer,
    output logic       receive,
    output logic [1:0] byte_count,
    output logic       done
);

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]  byte_count_d;
    logic [1:0]  data_select_d;
    logic        cs_d, transfer_d, receive_d, done_d;

    spi_sclk_gen #(.DIV(DIV)) u_sclk_gen (
        .clk       (clk),
        .rst_n     (power_btn),
        .sclk      (sclk),
        .sclk_rise (sclk_rise)
    );

    // State and registered outputs; everything advances only on an SCLK rising tick.
    always_ff @(posedge clk or negedge power_btn) begin
        if (!power_btn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            byte_count  <= '0;
            data_select <= '0;
            cs          <= 1'b1;
            transfer    <= 1'b0;
            receive     <= 1'b0;
            done        <= 1'b0;
        end else if (sclk_rise) begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            byte_count  <= byte_count_d;
            data_select <= data_select_d;
            cs          <= cs_d;
            transfer    <= transfer_d;
            receive     <= receive_d;
            done        <= done_d;
        end
    end

    // Next-state and counter logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        byte_count_d  = byte_count;
        data_select_d = data_select;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                data_select_d = 2'd1;
                state_d       = SELECT;
            end
            SELECT: begin
                bit_cnt_d    = '0;
                byte_count_d = '0;
                state_d      = XFER;
            end
            XFER: begin
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d    = '0;
                    byte_count_d = byte_count + 2'd1;
                    // Size check uses a 3-bit sum so the last byte is caught before byte_count could wrap.
                    if (({1'b0, byte_count} + 3'd1) == CMD_SIZE[data_select]) begin
                        done_d  = 1'b1;
                        state_d = GAP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'(GAP_TICKS - 1)) begin
                    gap_cnt_d = '0;
                    if (data_select < 2'(NUM_CMDS)) begin
                        data_select_d = data_select + 2'd1;
                        state_d       = SELECT;
                    end else begin
                        state_d = RECV;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            RECV: begin
                state_d = RECV;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cs_d       = !((state_d == SELECT) || (state_d == XFER) || (state_d == RECV));
        transfer_d = (state_d == XFER);
        receive_d  = (state_d == RECV);
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: reset, divider, command sequence, receive entry, async abort.
module tb_spi_cmd_sequencer;

    localparam int DIV = 20;

    logic       clk = 1'b0;
    logic       power_btn = 1'b0;
    logic       sclk, sclk_rise, cs, transfer, receive, done;
    logic [1:0] data_select, byte_count;

    int tests = 0;
    int fails = 0;

    spi_cmd_sequencer #(.DIV(DIV), .GAP_TICKS(4), .NUM_CMDS(3)) dut (
        .clk         (clk),
        .power_btn   (power_btn),
        .sclk        (sclk),
        .sclk_rise   (sclk_rise),
        .cs          (cs),
        .data_select (data_select),
        .transfer    (transfer),
        .receive     (receive),
        .byte_count  (byte_count),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Wait for the next sclk_rise pulse, then sample one cycle later (after the FSM has stepped).
    task automatic next_tick();
        int n = 0;
        while (sclk_rise !== 1'b1 && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (sclk_rise !== 1'b1) begin
            tests++; fails++;
            $display("FAIL tick_timeout: no sclk_rise within %0d clk, required one", 2 * DIV);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        power_btn = 1'b0;
        repeat (5) @(negedge clk);
        power_btn = 1'b1;
    endtask

    task automatic test_reset();
        int n = 0;
        bit seen = 0;
        power_btn = 1'b0;
        repeat (50) @(negedge clk);
        tests++;
        if ({sclk, sclk_rise, cs, transfer, receive, done} !== 6'b001000) begin
            fails++;
            $display("FAIL reset_ctrl: sclk,rise,cs,xfer,recv,done=%b required 001000",
                     {sclk, sclk_rise, cs, transfer, receive, done});
        end
        tests++;
        if (data_select !== 2'd0 || byte_count !== 2'd0) begin
            fails++;
            $display("FAIL reset_counts: data_select=%0d byte_count=%0d required 0 0", data_select, byte_count);
        end
        power_btn = 1'b1;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sclk_rise === 1'b1) seen = 1;
        end
        tests++;
        if (!seen || n != 10) begin
            fails++;
            $display("FAIL first_rise: at clk %0d (seen=%0d) required 10", n, seen);
        end
        tests++;
        if (sclk !== 1'b1) begin
            fails++;
            $display("FAIL first_rise_sclk: sclk=%b required 1", sclk);
        end
    endtask

    task automatic test_divider();
        logic prev = sclk;
        logic prev_rise = sclk_rise;
        int run = 1, first = 1, last_rise = 0, rises = 0;
        int bad_run = 0, bad_gap = 0, wide = 0, runs = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (sclk === prev) run++;
            else begin
                if (!first) begin
                    runs++;
                    if (run != 10) bad_run++;
                end
                first = 0;
                run = 1;
            end
            prev = sclk;
            if (sclk_rise === 1'b1) begin
                if (prev_rise === 1'b1) wide++;
                if (i - last_rise != 20) bad_gap++;
                last_rise = i;
                rises++;
            end
            prev_rise = sclk_rise;
        end
        tests++;
        if (bad_run != 0 || runs < 18) begin
            fails++;
            $display("FAIL div_duty: %0d bad half-periods of %0d, required 0 of >=18", bad_run, runs);
        end
        tests++;
        if (bad_gap != 0) begin
            fails++;
            $display("FAIL div_period: %0d rise spacings not 20 clk, required 0", bad_gap);
        end
        tests++;
        if (wide != 0 || rises != 10) begin
            fails++;
            $display("FAIL div_pulse: wide=%0d rises=%0d, required 0 and 10", wide, rises);
        end
    endtask

    task automatic test_command1();
        int tcnt, dcnt = 0, cscnt = 0, bad = 0;
        do_reset();
        next_tick();
        tests++;
        if (cs !== 1'b0 || data_select !== 2'd1 || transfer !== 1'b0) begin
            fails++;
            $display("FAIL cmd1_select: cs=%b ds=%0d xfer=%b required 0 1 0", cs, data_select, transfer);
        end
        next_tick();
        tests++;
        if (transfer !== 1'b1 || byte_count !== 2'd0 || cs !== 1'b0) begin
            fails++;
            $display("FAIL cmd1_start: xfer=%b bc=%0d cs=%b required 1 0 0", transfer, byte_count, cs);
        end
        tcnt = 1;
        for (int t = 3; t <= 30; t++) begin
            next_tick();
            if (transfer === 1'b1) tcnt++;
            if (done === 1'b1) dcnt++;
            if (t <= 26 && byte_count !== 2'((t - 2) / 8)) bad++;
            if (t >= 26 && cs === 1'b1) cscnt++;
            if (t == 26 && (done !== 1'b1 || transfer !== 1'b0)) bad++;
        end
        tests++;
        if (tcnt != 24) begin
            fails++;
            $display("FAIL cmd1_xfer_len: transfer high %0d ticks, required 24", tcnt);
        end
        tests++;
        if (dcnt != 1 || bad != 0) begin
            fails++;
            $display("FAIL cmd1_bytes: done pulses=%0d byte errors=%0d, required 1 and 0", dcnt, bad);
        end
        tests++;
        if (cscnt != 4) begin
            fails++;
            $display("FAIL cmd1_gap: cs high %0d ticks, required 4", cscnt);
        end
        tests++;
        if (cs !== 1'b0 || data_select !== 2'd2 || byte_count !== 2'd3) begin
            fails++;
            $display("FAIL cmd1_next: cs=%b ds=%0d bc=%0d required 0 2 3", cs, data_select, byte_count);
        end
    endtask

    task automatic test_command2();
        int tcnt, dcnt = 0, bad = 0;
        next_tick();
        tests++;
        if (transfer !== 1'b1 || byte_count !== 2'd0 || data_select !== 2'd2) begin
            fails++;
            $display("FAIL cmd2_start: xfer=%b bc=%0d ds=%0d required 1 0 2", transfer, byte_count, data_select);
        end
        tcnt = 1;
        for (int t = 32; t <= 51; t++) begin
            next_tick();
            if (transfer === 1'b1) tcnt++;
            if (done === 1'b1) dcnt++;
            if (t == 47 && (byte_count !== 2'd2 || done !== 1'b1 || transfer !== 1'b0)) bad++;
        end
        tests++;
        if (tcnt != 16 || dcnt != 1 || bad != 0) begin
            fails++;
            $display("FAIL cmd2_xfer: len=%0d done=%0d end errors=%0d, required 16 1 0", tcnt, dcnt, bad);
        end
        tests++;
        if (data_select !== 2'd3 || cs !== 1'b0 || byte_count !== 2'd2) begin
            fails++;
            $display("FAIL cmd2_next: ds=%0d cs=%b bc=%0d required 3 0 2", data_select, cs, byte_count);
        end
    endtask

    task automatic test_completion();
        int tcnt = 0, dcnt = 0, bad = 0;
        for (int t = 52; t <= 80; t++) begin
            next_tick();
            if (transfer === 1'b1) tcnt++;
            if (done === 1'b1) dcnt++;
        end
        tests++;
        if (tcnt != 24 || dcnt != 1) begin
            fails++;
            $display("FAIL cmd3_xfer: len=%0d done=%0d, required 24 1", tcnt, dcnt);
        end
        tests++;
        if (cs !== 1'b0 || receive !== 1'b1 || data_select !== 2'd3 || transfer !== 1'b0) begin
            fails++;
            $display("FAIL recv_entry: cs=%b recv=%b ds=%0d xfer=%b required 0 1 3 0",
                     cs, receive, data_select, transfer);
        end
        for (int k = 0; k < 100; k++) begin
            next_tick();
            if (cs !== 1'b0 || receive !== 1'b1 || data_select !== 2'd3 ||
                transfer !== 1'b0 || done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL recv_hold: %0d ticks left receive state, required 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int t = 1; t <= 42; t++) next_tick();
        tests++;
        if (data_select !== 2'd2 || byte_count !== 2'd1 || transfer !== 1'b1) begin
            fails++;
            $display("FAIL abort_setup: ds=%0d bc=%0d xfer=%b required 2 1 1", data_select, byte_count, transfer);
        end
        #3;
        power_btn = 1'b0;
        #1;
        tests++;
        if ({sclk, sclk_rise, cs, transfer, receive, done, data_select, byte_count} !== 10'b0010000000) begin
            fails++;
            $display("FAIL abort_async: outputs=%b required 0010000000",
                     {sclk, sclk_rise, cs, transfer, receive, done, data_select, byte_count});
        end
        repeat (3) @(negedge clk);
        power_btn = 1'b1;
        next_tick();
        tests++;
        if (data_select !== 2'd1 || cs !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: ds=%0d cs=%b required 1 0", data_select, cs);
        end
        next_tick();
        tests++;
        if (transfer !== 1'b1 || byte_count !== 2'd0) begin
            fails++;
            $display("FAIL abort_xfer: xfer=%b bc=%0d required 1 0", transfer, byte_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divider();
        test_command1();
        test_command2();
        test_completion();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
